// File: rtl/clock_pkg.sv
// Shared clock constants and divisor type for the
// programmable clock divider and its scan counter.
package clock_pkg;

  localparam int CLK_FREQ_HZ     = 50000000;
  localparam int HALF_PERIOD_1HZ = 25000000;
  localparam int SCAN_1KHZ       = 50000;
  localparam int DIV_CNT_W       = 25;

  typedef logic [DIV_CNT_W-1:0] div_t;

endpackage

// File: rtl/tick_counter.sv
// Free-running modulo-N counter with a registered
// single-cycle wrap pulse.
module tick_counter
  import clock_pkg::*;
#(
  parameter int N = SCAN_1KHZ,
  parameter int W = 16
) (
  input  logic clk_50Mhz,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;
  logic         r_wrap;

  // count 0..N-1, pulse wrap on the N-1 -> 0 step
  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (r_cnt >= LAST) begin
        r_cnt  <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + W'(1);
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign wrap = r_wrap;

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable 50% duty clock divider with tick strobes,
// glitch-free divisor updates and a fixed-rate scan tick.
module prog_clock_divider
  import clock_pkg::*;
#(
  parameter int CNT_W       = DIV_CNT_W,
  parameter int DIV_DEFAULT = HALF_PERIOD_1HZ,
  parameter int SCAN_DIV    = SCAN_1KHZ,
  parameter int SCAN_W      = 16
) (
  input  logic             clk_50Mhz,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             half_tick,
  output logic             scan_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_active;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_valid;
  logic             r_div_ack;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_half_tick;

  logic             w_run;
  logic             w_wrap;
  logic             w_rise;
  logic             w_apply;
  logic [CNT_W-1:0] w_load_val;
  logic             w_scan_wrap;

  assign w_run  = enable & ~sync_clr;
  // >= keeps a freshly shrunken divisor from overrunning
  assign w_wrap = r_cnt >= (r_div_active - CNT_W'(1));
  assign w_rise = w_run & w_wrap & ~r_clk_out;

  // swap divisor at a period start, or at once when idle
  assign w_apply = r_pend_valid & (w_rise | ~w_run);

  assign w_load_val = (div_value == '0) ? CNT_W'(1)
                                        : div_value;

  // half-period counter, output toggle and strobes
  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
      r_half_tick <= 1'b0;
    end else if (sync_clr) begin
      r_cnt       <= '0;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
      r_half_tick <= 1'b0;
    end else if (enable) begin
      if (w_wrap) begin
        r_cnt       <= '0;
        r_clk_out   <= ~r_clk_out;
        r_half_tick <= 1'b1;
        r_tick      <= ~r_clk_out;
      end else begin
        r_cnt       <= r_cnt + CNT_W'(1);
        r_half_tick <= 1'b0;
        r_tick      <= 1'b0;
      end
    end else begin
      r_tick      <= 1'b0;
      r_half_tick <= 1'b0;
    end
  end

  // pending/active divisor registers and apply acknowledge
  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_div_active <= CNT_W'(DIV_DEFAULT);
      r_pend_div   <= CNT_W'(DIV_DEFAULT);
      r_pend_valid <= 1'b0;
      r_div_ack    <= 1'b0;
    end else begin
      r_div_ack <= w_apply;
      if (w_apply) begin
        r_div_active <= r_pend_div;
      end
      if (div_load) begin
        r_pend_div   <= w_load_val;
        r_pend_valid <= 1'b1;
      end else if (w_apply) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  tick_counter #(
    .N (SCAN_DIV),
    .W (SCAN_W)
  ) u_scan (
    .clk_50Mhz (clk_50Mhz),
    .reset_n   (reset_n),
    .clr       (1'b0),
    .en        (1'b1),
    .wrap      (w_scan_wrap)
  );

  assign div_ack   = r_div_ack;
  assign clk_out   = r_clk_out;
  assign tick      = r_tick;
  assign half_tick = r_half_tick;
  assign scan_tick = w_scan_wrap;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with small
// divisors and hand-computed per-cycle output vectors.
module tb_prog_clock_divider;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       ld;
  logic [7:0] dval;
  logic       ack;
  logic       cko;
  logic       tk;
  logic       htk;
  logic       stk;

  int n_total;
  int n_bad;
  int cyc;

  logic [31:0] v_clk;
  logic [31:0] v_tick;
  logic [31:0] v_half;
  logic [31:0] v_ack;
  logic [31:0] v_scan;
  logic [31:0] e_scan;

  prog_clock_divider #(
    .CNT_W       (8),
    .DIV_DEFAULT (4),
    .SCAN_DIV    (3),
    .SCAN_W      (2)
  ) dut (
    .clk_50Mhz (clk),
    .reset_n   (rst_n),
    .enable    (en),
    .sync_clr  (clr),
    .div_load  (ld),
    .div_value (dval),
    .div_ack   (ack),
    .clk_out   (cko),
    .tick      (tk),
    .half_tick (htk),
    .scan_tick (stk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    v_clk  = '0;
    v_tick = '0;
    v_half = '0;
    v_ack  = '0;
    v_scan = '0;
    e_scan = '0;
    for (int i = 0; i < n; i++) begin
      step();
      v_clk[i]  = cko;
      v_tick[i] = tk;
      v_half[i] = htk;
      v_ack[i]  = ack;
      v_scan[i] = stk;
      e_scan[i] = (cyc % 3 == 0);
    end
  endtask

  task automatic load(input logic [7:0] v);
    ld   = 1'b1;
    dval = v;
    step();
    ld   = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    clr     = 1'b0;
    ld      = 1'b0;
    dval    = '0;

    #3;
    chk("reset_outs", {27'd0, ack, cko, tk, htk, stk}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // default divisor 4, scan 3
    run(24);
    chk("t1_clk",  v_clk,  32'h787878);
    chk("t1_tick", v_tick, 32'h080808);
    chk("t1_half", v_half, 32'h888888);
    chk("t1_scan", v_scan, 32'h924924);
    chk("t1_ack",  v_ack,  32'h0);

    // load 2 in the high phase
    run(5);
    chk("t2_pre_clk", {31'd0, cko}, 32'd1);
    load(8'd2);
    chk("t2_ld_ack", {31'd0, ack}, 32'd0);
    run(16);
    chk("t2_clk",  v_clk,  32'h6661);
    chk("t2_tick", v_tick, 32'h2220);
    chk("t2_half", v_half, 32'haaa2);
    chk("t2_ack",  v_ack,  32'h0020);

    // zero divisor acts as 1
    load(8'd0);
    run(8);
    chk("t3_clk",  v_clk,  32'h55);
    chk("t3_tick", v_tick, 32'h55);
    chk("t3_half", v_half, 32'hff);
    chk("t3_ack",  v_ack,  32'h01);

    // back-to-back loads, last wins
    load(8'd6);
    chk("t3_ld6_ack", {31'd0, ack}, 32'd0);
    load(8'd3);
    chk("t3_ld3_ack", {31'd0, ack}, 32'd0);
    run(12);
    chk("t3b_clk",  v_clk,  32'h1c7);
    chk("t3b_tick", v_tick, 32'h041);
    chk("t3b_ack",  v_ack,  32'h001);

    // disabled: freeze, scan keeps going
    en = 1'b0;
    run(10);
    chk("t4_clk",  v_clk,  32'h0);
    chk("t4_tick", v_tick, 32'h0);
    chk("t4_half", v_half, 32'h0);
    chk("t4_scan", v_scan, e_scan);
    load(8'd2);
    chk("t4_ld_ack", {31'd0, ack}, 32'd0);
    step();
    chk("t4_ack", {31'd0, ack}, 32'd1);
    step();
    chk("t4_ack_end", {31'd0, ack}, 32'd0);
    en = 1'b1;
    run(4);
    chk("t4_re_clk",  v_clk,  32'h3);
    chk("t4_re_tick", v_tick, 32'h1);
    chk("t4_re_ack",  v_ack,  32'h0);

    // sync clear in the high phase
    step();
    step();
    chk("t5_pre_clk", {31'd0, cko}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr", {29'd0, cko, tk, htk}, 32'd0);
    run(4);
    chk("t5_clk",  v_clk,  32'h6);
    chk("t5_tick", v_tick, 32'h2);

    // async reset with a pending divisor
    step();
    step();
    load(8'd7);
    chk("t6_pre_clk", {31'd0, cko}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {27'd0, ack, cko, tk, htk, stk},
        32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run(24);
    chk("t6_clk",  v_clk,  32'h787878);
    chk("t6_tick", v_tick, 32'h080808);
    chk("t6_scan", v_scan, 32'h924924);
    chk("t6_ack",  v_ack,  32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Parametrised successor to the fixed 50 MHz→1 Hz divider. It generates a 50%-duty square clock enable (clk_out) from clk_50Mhz with a run-time programmable half-period. It also produces single-cycle tick strobes for the time-keeping counters and an independent fixed-rate scan tick for the display multiplexer. Divisor changes are glitch-free: they are applied only at a full-period boundary, and a one-cycle acknowledge reports when the change takes effect.

Parameters:
CNT_W, 25, width of half-period counter and divisor bus
DIV_DEFAULT, 25000000, half-period in clk cycles after reset (1 Hz at 50 MHz)
SCAN_DIV, 50000, scan_tick period in clk cycles (1 kHz at 50 MHz), must be >= 1
SCAN_W, 16, width of scan counter, must satisfy 2**SCAN_W >= SCAN_DIV

Ports:
clk_50Mhz  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = main divider runs; 0 = hold counter and clk_out
sync_clr  input  1  synchronous clear of main divider phase
div_load  input  1  one-cycle strobe, capture div_value as pending divisor
div_value  input  CNT_W  new half-period in cycles; 0 treated as 1
div_ack  output  1  one-cycle pulse when pending divisor becomes active
clk_out  output  1  divided square wave (registered)
tick  output  1  one-cycle pulse coincident with clk_out 0->1
half_tick  output  1  one-cycle pulse on every clk_out toggle
scan_tick  output  1  one-cycle pulse every SCAN_DIV cycles, free-running

Behaviour:
- Reset (reset_n=0, asynchronous):
  - cnt=0, clk_out=0, tick=0, half_tick=0, div_ack=0, scan_tick=0, scan_cnt=0.
  - div_active=DIV_DEFAULT, pend_valid=0.
- Main counter, when enable=1 and sync_clr=0:
  - Wrap condition is cnt >= div_active-1, using >= so that a shrunken divisor never overruns.
  - On wrap: cnt<=0, clk_out<=~clk_out, half_tick<=1, tick<=1 only if clk_out was 0.
  - Otherwise: cnt<=cnt+1.
  - tick and half_tick are registered, so they assert in the same cycle clk_out changes.
  - Full period is 2*div_active cycles.
- enable=0: cnt and clk_out hold; tick=half_tick=0.
- sync_clr=1 (priority over enable):
  - cnt<=0, clk_out<=0, no tick/half_tick.
  - Pending divisor is kept, not discarded.
- Divisor load:
  - div_load=1 captures max(div_value,1) into pend_div and sets pend_valid.
  - A load while pend_valid=1 overwrites pend_div; only the last value is applied, with one div_ack.
- Apply point:
  - Enabled: the wrap cycle in which clk_out goes 0->1 (start of a new period). div_active<=pend_div, pend_valid<=0, div_ack<=1 in the same cycle as tick.
  - enable=0 or sync_clr=1: apply on the next clock edge (div_ack one cycle after the div_load cycle).
  - div_load in the same cycle as an apply point: the current pend_div (if any) is applied, and the new value becomes pending for the next period.
  - div_load with pend_valid=0 exactly at a 0->1 wrap: the value is captured and applied at the next 0->1 wrap, not this one.
- div_active=1: clk_out toggles every enabled cycle (25 MHz square); tick pulses every 2nd cycle.
- Scan channel:
  - Modulo-SCAN_DIV counter, independent of enable, sync_clr and divisor.
  - scan_tick=1 for one cycle when scan_cnt wraps from SCAN_DIV-1 to 0. First pulse comes SCAN_DIV cycles after reset release.
- Reset mid-operation: asynchronously forces the reset values above; any pending divisor is lost.
- Widths: counters are unsigned, and the compare is done at CNT_W bits. The divisor is not checked against CNT_W beyond the truncation given by the port width.

Decomposition:
- Shared package clock_pkg:
  - CLK_FREQ_HZ=50000000, HALF_PERIOD_1HZ=25000000, SCAN_1KHZ=50000, DIV_CNT_W=25.
  - Divisor type as logic [DIV_CNT_W-1:0].
- Sub-module tick_counter (parameters N, W; ports clk_50Mhz, reset_n, clr, en, wrap): free-running modulo-N counter with a registered wrap pulse.
  - Instantiated for the scan channel.
  - The main divider stays inline because it needs the variable divisor and toggle logic.

Test Plan:
1. DIV_DEFAULT=4, SCAN_DIV=3, enable=1 after reset release -> clk_out 0 for 4 cycles, 1 for 4, period 8; tick on cycles 4, 12, 20; half_tick on cycles 4, 8, 12; scan_tick on cycles 3, 6, 9.
2. Mid-high-phase div_load, div_value=2 -> no change until next 0->1 wrap; div_ack coincides with that tick; following periods are 4 cycles (2 high, 2 low).
3. div_value=0 load, then div_load twice back-to-back (values 6, 3) -> 0 is applied as 1 (toggle every cycle); for the pair, a single div_ack and div_active=3.
4. enable=0 for 10 cycles with cnt=2 -> clk_out and cnt frozen, no ticks, scan_tick keeps its 3-cycle cadence; a div_load here acks next cycle.
5. sync_clr pulse while clk_out=1 -> next cycle clk_out=0, cnt=0; first tick arrives div_active cycles after clear release.
6. reset_n low asynchronously mid-period with pend_valid=1 -> all outputs 0 immediately; after release, period back to 2*DIV_DEFAULT and no div_ack ever fires.
